// File: rtl/alu_exec_unit_if.sv
// Request/response bundle for alu_exec_unit: launch handshake, operands and the
// registered result with its zero flag.
interface alu_exec_unit_if;
  logic        start;
  logic [3:0]  alu_control;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;

  modport master (output start, alu_control, a, b,
                  input  busy, done, result, zero);
  modport slave  (input  start, alu_control, a, b,
                  output busy, done, result, zero);
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: one-cycle arithmetic/logic/compare/link ops, and shifts that
// iterate one bit per cycle. Result and zero flag are registered together.
module alu_exec_unit (
  input  logic           clk,
  input  logic           rst,
  alu_exec_unit_if.slave bus
);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]  state;
  logic [31:0] acc, acc_nxt, res_c, result_q;
  logic [4:0]  cnt, shamt;
  logic        sh_right, sh_arith, done_q, zero_q, is_shift;

  assign shamt    = bus.b[4:0];
  assign is_shift = (bus.alu_control == 4'b0001) || (bus.alu_control[2:0] == 3'b101);

  always_comb begin
    res_c = '0;
    case (bus.alu_control)
      4'b0000: res_c = bus.a + bus.b;
      4'b1000: res_c = bus.a - bus.b;
      4'b1001: res_c = bus.a + 32'd4;
      4'b0010: res_c = {31'b0, $signed(bus.a) <  $signed(bus.b)};
      4'b1010: res_c = {31'b0, $signed(bus.a) >= $signed(bus.b)};
      4'b0011: res_c = {31'b0, bus.a <  bus.b};
      4'b1011: res_c = {31'b0, bus.a >= bus.b};
      4'b0100: res_c = bus.a ^ bus.b;
      4'b1100: res_c = ~(bus.a ^ bus.b);
      4'b0110, 4'b1110: res_c = bus.a | bus.b;
      4'b0111, 4'b1111: res_c = bus.a & bus.b;
      // Shifts only complete here when shamt is zero, i.e. the operand passes through.
      4'b0001, 4'b0101, 4'b1101: res_c = bus.a;
      default: res_c = '0;
    endcase
  end

  always_comb begin
    acc_nxt = {acc[30:0], 1'b0};
    if (sh_right) acc_nxt = {sh_arith & acc[31], acc[31:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      cnt      <= '0;
      sh_right <= 1'b0;
      sh_arith <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (is_shift && shamt != 5'd0) begin
              state    <= S_SHIFT;
              acc      <= bus.a;
              cnt      <= shamt;
              sh_right <= bus.alu_control[2];
              sh_arith <= bus.alu_control[3];
            end else begin
              result_q <= res_c;
              zero_q   <= (res_c == 32'd0);
              done_q   <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          acc <= acc_nxt;
          cnt <= cnt - 5'd1;
          // Last bit: publish the shifted value directly rather than waiting a cycle.
          if (cnt == 5'd1) begin
            result_q <= acc_nxt;
            zero_q   <= (acc_nxt == 32'd0);
            done_q   <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state == S_SHIFT);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
endmodule
